// File: rtl/vram_scanout_pkg.sv
// vram_scanout_pkg: 640x480@60 timing constants, pixel/sync types and the NTSC TIA palette table
package vram_scanout_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int FB_STRIDE = 160;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // per-pixel control bits carried alongside the colour through the pipeline
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic frame;
      logic odd;
   } sync_t;

   // indexed by COLUx[7:1]: 16 hues x 8 luminances
   localparam logic [23:0] NTSC_PAL [128] = '{
      24'h000000, 24'h4a4a4a, 24'h6f6f6f, 24'h8e8e8e, 24'haaaaaa, 24'hc0c0c0, 24'hd6d6d6, 24'hececec,
      24'h484800, 24'h69690f, 24'h86861d, 24'ha2a22a, 24'hbbbb35, 24'hd2d240, 24'he8e84a, 24'hfcfc54,
      24'h7c2c00, 24'h904811, 24'ha26221, 24'hb47a30, 24'hc3903d, 24'hd2a44a, 24'hdfb755, 24'hecc860,
      24'h901c00, 24'ha33915, 24'hb55328, 24'hc66c3a, 24'hd5824a, 24'he39759, 24'hf0aa67, 24'hfcbc74,
      24'h940000, 24'ha71a1a, 24'hb83232, 24'hc84848, 24'hd65c5c, 24'he46f6f, 24'hf08080, 24'hfc9090,
      24'h840064, 24'h97197a, 24'ha8308f, 24'hb846a2, 24'hc659b3, 24'hd46cc3, 24'he07cd2, 24'hec8ce0,
      24'h500084, 24'h68199a, 24'h7d30ad, 24'h9246c0, 24'ha459d0, 24'hb56ce0, 24'hc57cee, 24'hd48cfc,
      24'h140090, 24'h331aa3, 24'h4e32b5, 24'h6848c6, 24'h7f5cd5, 24'h956fe3, 24'ha980f0, 24'hbc90fc,
      24'h000094, 24'h181aa7, 24'h2d32b8, 24'h4248c8, 24'h545cd6, 24'h656fe4, 24'h7580f0, 24'h8490fc,
      24'h001c88, 24'h183b9d, 24'h2d57b0, 24'h4272c2, 24'h548ad2, 24'h65a0e1, 24'h75b5ef, 24'h84c8fc,
      24'h003064, 24'h185080, 24'h2d6d98, 24'h4288b0, 24'h54a0c5, 24'h65b7d9, 24'h75cceb, 24'h84e0fc,
      24'h004030, 24'h18624e, 24'h2d8169, 24'h429e82, 24'h54b899, 24'h65d1ae, 24'h75e7c2, 24'h84fcd4,
      24'h004400, 24'h1a661a, 24'h328432, 24'h48a048, 24'h5cba5c, 24'h6fd26f, 24'h80e880, 24'h90fc90,
      24'h143c00, 24'h355f18, 24'h527e2d, 24'h6e9c42, 24'h87b754, 24'h9ed065, 24'hb4e775, 24'hc8fc84,
      24'h303800, 24'h505916, 24'h6d762b, 24'h88923e, 24'ha0ab4f, 24'hb7c25f, 24'hccd86e, 24'he0ec7c,
      24'h482c00, 24'h694d14, 24'h866a26, 24'ha28638, 24'hbb9f47, 24'hd2b656, 24'he8cc63, 24'hfce070
   };
endpackage

// File: rtl/ntsc_palette.sv
// ntsc_palette: registered 128-entry TIA colour index to 24-bit RGB lookup
module ntsc_palette
   import vram_scanout_pkg::*;
(
   input  logic       clk,
   input  logic [6:0] idx,
   output rgb_t       rgb
);
   // one-cycle ROM read; no reset, the consumer blanks it with its own DE
   always_ff @(posedge clk)
      rgb <= NTSC_PAL[idx];
endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: 640x480 scan-out with 4x/2x frame-buffer replication; SCANLINES_EN halves odd lines
module vram_scanout
   import vram_scanout_pkg::*;
#(
   parameter int H_VIS = H_VISIBLE,
   parameter int V_VIS = V_VISIBLE,
   parameter int FB_W  = FB_STRIDE,
   parameter int FB_H  = 240
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [15:0] vga_addr,
   input  logic [6:0]  vga_data,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_de,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_o
);
   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG = H_VIS + H_FP;
   localparam int VS_BEG = V_VIS + V_FP;
`ifdef SCANLINES_EN
   localparam bit DIM = 1'b1;
`else
   localparam bit DIM = 1'b0;
`endif

   logic [9:0]  h, v;
   logic [15:0] line_base;
   logic        h_end, v_end;
   sync_t       sync_now;
   sync_t [2:0] sync_d;
   rgb_t        pix, shade;

   assign h_end    = h == 10'(H_TOT - 1);
   assign v_end    = v == 10'(V_TOT - 1);
   assign sync_now = {h < 10'(H_VIS) && v < 10'(V_VIS),
                      h >= 10'(HS_BEG) && h < 10'(HS_BEG + H_SYNC),
                      v >= 10'(VS_BEG) && v < 10'(VS_BEG + V_SYNC),
                      v == 10'(V_VIS) && h == '0,
                      v[0]};

   // raster position; v advances at the end of each line
   always_ff @(posedge clk_i)
      if (!rst_ni) begin
         h <= '0;
         v <= '0;
      end else begin
         h <= h_end ? '0 : h + 10'd1;
         if (h_end) v <= v_end ? '0 : v + 10'd1;
      end

   // line_base steps one stride after every second line, so no multiplier is needed
   always_ff @(posedge clk_i)
      if (!rst_ni) begin
         line_base <= '0;
         vga_addr  <= '0;
      end else begin
         if (sync_now.de) vga_addr <= line_base + 16'(h[9:2]);
         if (h_end && v_end) line_base <= '0;
         else if (h_end && v[0] && v < 10'(2 * FB_H - 1)) line_base <= line_base + 16'(FB_W);
      end

   // three-stage delay matching address, RAM and palette latency
   always_ff @(posedge clk_i)
      if (!rst_ni) sync_d <= '0;
      else sync_d <= {sync_d[1:0], sync_now};

   ntsc_palette u_pal (
      .clk (clk_i),
      .idx (vga_data),
      .rgb (pix)
   );

   assign shade = (DIM && sync_d[2].odd) ? {1'b0, pix.r[7:1], 1'b0, pix.g[7:1], 1'b0, pix.b[7:1]} : pix;
   assign {vga_r, vga_g, vga_b} = sync_d[2].de ? shade : '0;
   assign vga_de  = sync_d[2].de;
   assign vga_hs  = sync_d[2].hs;
   assign vga_vs  = sync_d[2].vs;
   assign frame_o = sync_d[2].frame;
endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: random frame-buffer contents checked cycle by cycle against a raster model
module tb_vram_scanout;
   localparam int HV = 64;
   localparam int VV = 16;
   localparam int FW = 16;
   localparam int FH = 8;
   localparam int HT = HV + 16 + 96 + 48;
   localparam int VT = VV + 10 + 2 + 33;
   localparam logic [6:0]  PAL_IDX [8] = '{7'h00, 7'h07, 7'h0f, 7'h20, 7'h27, 7'h40, 7'h66, 7'h7f};
   localparam logic [23:0] PAL_RGB [8] = '{24'h000000, 24'hececec, 24'hfcfc54, 24'h940000,
                                          24'hfc9090, 24'h000094, 24'h80e880, 24'hfce070};

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [15:0] vga_addr;
   logic [6:0]  vga_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_de, vga_hs, vga_vs, frame_o;
   logic [6:0]  fb [FW * FH];

   int          chk_cnt = 0, pass_cnt = 0;
   int          k = 0, prev_fk = -1, frames = 0;
   int          de_run = 0, hs_run = 0, vs_run = 0, de_rise = -1;
   logic        de_q = 1'b0, hs_q = 1'b0;
   logic [15:0] exp_addr = '0;

   vram_scanout #(.H_VIS(HV), .V_VIS(VV), .FB_W(FW), .FB_H(FH)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .vga_addr (vga_addr),
      .vga_data (vga_data),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b),
      .vga_de   (vga_de),
      .vga_hs   (vga_hs),
      .vga_vs   (vga_vs),
      .frame_o  (frame_o)
   );

   always #20 clk = ~clk;

   // frame-buffer second port: registered read
   always @(posedge clk)
      vga_data <= fb[int'(vga_addr) % (FW * FH)];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d after release)", tag, got, exp, k);
   endtask

   function automatic logic [23:0] rgb_of(input logic [6:0] idx);
      for (int i = 0; i < 8; i++)
         if (PAL_IDX[i] == idx) return PAL_RGB[i];
      return 24'h0;
   endfunction

   // expected {de,hs,vs,frame,rgb} for the m-th raster position since reset
   function automatic logic [27:0] exp_out(input int m);
      int hh = m % HT;
      int vv = (m / HT) % VT;
      logic de = hh < HV && vv < VV;
      logic [23:0] c = de ? rgb_of(fb[(vv / 2) * FW + hh / 4]) : 24'h0;
`ifdef SCANLINES_EN
      if (vv % 2 == 1) c = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`endif
      return {de, hh >= HV + 16 && hh < HV + 112, vv >= VV + 10 && vv < VV + 12, vv == VV && hh == 0, c};
   endfunction

   task automatic step();
      int hh, vv;
      logic [27:0] eo;
      @(posedge clk);
      #1;
      k = rst_ni ? k + 1 : 0;
      if (k == 0) exp_addr = '0;
      else begin
         hh = (k - 1) % HT;
         vv = ((k - 1) / HT) % VT;
         if (hh < HV && vv < VV) exp_addr = 16'((vv / 2) * FW + hh / 4);
      end
      eo = k >= 3 ? exp_out(k - 3) : 28'h0;
      check("out", {vga_de, vga_hs, vga_vs, frame_o, vga_r, vga_g, vga_b, vga_addr}, {eo, exp_addr});
      if (k == 0) begin
         prev_fk = -1;
         de_run = 0;
         hs_run = 0;
         vs_run = 0;
         de_rise = -1;
      end else begin
         if (frame_o) begin
            frames++;
            if (prev_fk < 0) check("frame_first", k, VV * HT + 3);
            else check("frame_period", k - prev_fk, HT * VT);
            prev_fk = k;
         end
         if (vga_de && !de_q) de_rise = k;
         if (vga_hs && !hs_q && de_rise >= 0 && k - de_rise < HT) check("hs_offset", k - de_rise, HV + 16);
         if (vga_de) de_run++;
         else if (de_run > 0) begin
            check("de_width", de_run, HV);
            de_run = 0;
         end
         if (vga_hs) hs_run++;
         else if (hs_run > 0) begin
            check("hs_width", hs_run, 96);
            hs_run = 0;
         end
         if (vga_vs) vs_run++;
         else if (vs_run > 0) begin
            check("vs_width", vs_run, 2 * HT);
            vs_run = 0;
         end
      end
      de_q = vga_de;
      hs_q = vga_hs;
   endtask

   initial begin
      for (int i = 0; i < FW * FH; i++) fb[i] = 7'h00;
      fb[0] = 7'h07;
      rst_ni = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst_ni = 1'b1;
      frames = 0;
      for (int i = 0; i < 18000; i++) step();
      check("frame_count", frames, 2);
      for (int i = 0; i < FW * FH; i++) fb[i] = PAL_IDX[$urandom_range(7)];
      for (int i = 0; i < int'($urandom_range(3000, 1000)); i++) step();
      rst_ni = 1'b0;
      for (int i = 0; i < FW * FH; i++) fb[i] = PAL_IDX[$urandom_range(7)];
      for (int i = 0; i < int'($urandom_range(5, 1)); i++) step();
      rst_ni = 1'b1;
      frames = 0;
      for (int i = 0; i < 18000; i++) step();
      check("frame_count", frames, 2);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
